bouncing_box_gen: RTL

- Pixel-source stage that sits upstream of the VGA output pins, in the 800x600 @ 72 Hz, 50 MHz pixel-clock design.
- Consumes the timing generator's horizontal/vertical counters, visible flag and sync pulses.
- Produces a 6-bit RGB word for a square box that moves and bounces inside the visible area.
- Registers RGB and sync together, so the pins see a consistent one-cycle-delayed stream. Buttons pause motion, recentre the box and cycle its colour.

---
 rtl/bouncing_box_gen.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/bouncing_box_gen.sv
// bouncing_box_gen: draws a square box that bounces inside the 800x600 visible
// area and re-times RGB together with the sync pulses so the pins see one
// consistent stream delayed by one pixel clock.
// Position, direction and colour change only on the frame tick, which is the
// first pixel of the first blank line, so a frame never shows a torn box.
// Optional build macro HIT_FLASH_EN: after a wall bounce the box renders white
// for seven frames before returning to its palette colour.
//
// Axis direction encoding:
//   dir     | meaning
//   DIR_INC | coordinate grows each tick (moving right / moving down)
//   DIR_DEC | coordinate shrinks each tick (moving left / moving up)

module bouncing_box_gen #(
   parameter int BOX  = 32,
   parameter int STEP = 2,
   parameter int HVIS = 800,
   parameter int VVIS = 600
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [11:0] i_hor_cntr,
   input  logic [10:0] i_ver_cntr,
   input  logic        i_visible,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [2:0]  i_bt,
   output logic [5:0]  o_rgb,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_hit
);

   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_t;

   localparam logic [11:0] XMIN  = 12'd1;
   localparam logic [11:0] XMAX  = 12'(HVIS - BOX + 1);
   localparam logic [11:0] XCTR  = 12'((HVIS - BOX) / 2 + 1);
   localparam logic [11:0] XSTEP = 12'(STEP);
   localparam logic [10:0] YMIN  = 11'd1;
   localparam logic [10:0] YMAX  = 11'(VVIS - BOX + 1);
   localparam logic [10:0] YCTR  = 11'((VVIS - BOX) / 2 + 1);
   localparam logic [10:0] YSTEP = 11'(STEP);
   localparam logic [10:0] VTICK = 11'(VVIS + 1);

   logic [2:0]  r_bt_meta;
   logic [2:0]  r_bt_sync;
   logic [2:1]  r_bt_prev;
   logic        r_pend_col;
   logic        r_pend_ctr;
   logic [11:0] r_x;
   logic [10:0] r_y;
   dir_t        r_dir_x;
   dir_t        r_dir_y;
   logic [1:0]  r_col;

   logic [2:1]  w_edge;
   logic        w_tick;
   logic        w_pend_col;
   logic        w_pend_ctr;
   logic        w_paused;
   logic [12:0] w_x_sum;
   logic [11:0] w_x_nxt;
   dir_t        w_dir_x_nxt;
   logic        w_bx;
   logic [11:0] w_y_sum;
   logic [10:0] w_y_nxt;
   dir_t        w_dir_y_nxt;
   logic        w_by;
   logic        w_bounce;
   logic        w_inside;
   logic [5:0]  w_pal;
   logic [5:0]  w_pix;
   logic        w_flash_on;

   assign w_edge     = r_bt_sync[2:1] & ~r_bt_prev;
   assign w_tick     = (i_ver_cntr == VTICK) && (i_hor_cntr == 12'd0);
   // An edge landing exactly on the tick cycle is honoured rather than dropped.
   assign w_pend_col = r_pend_col | w_edge[1];
   assign w_pend_ctr = r_pend_ctr | w_edge[2];
   assign w_paused   = r_bt_sync[0];
   assign w_x_sum    = {1'b0, r_x} + {1'b0, XSTEP};
   assign w_y_sum    = {1'b0, r_y} + {1'b0, YSTEP};
   assign w_bounce   = w_tick && !w_pend_ctr && !w_paused && (w_bx || w_by);

   // Next horizontal position and direction if this tick moves the box.
   always_comb begin
      w_x_nxt     = r_x;
      w_dir_x_nxt = r_dir_x;
      w_bx        = 1'b0;
      if (r_dir_x == DIR_INC) begin
         if (w_x_sum >= {1'b0, XMAX}) begin
            w_x_nxt     = XMAX;
            w_dir_x_nxt = DIR_DEC;
            w_bx        = 1'b1;
         end else begin
            w_x_nxt = w_x_sum[11:0];
         end
      end else begin
         if (r_x <= XMIN + XSTEP) begin
            w_x_nxt     = XMIN;
            w_dir_x_nxt = DIR_INC;
            w_bx        = 1'b1;
         end else begin
            w_x_nxt = r_x - XSTEP;
         end
      end
   end

   // Next vertical position and direction if this tick moves the box.
   always_comb begin
      w_y_nxt     = r_y;
      w_dir_y_nxt = r_dir_y;
      w_by        = 1'b0;
      if (r_dir_y == DIR_INC) begin
         if (w_y_sum >= {1'b0, YMAX}) begin
            w_y_nxt     = YMAX;
            w_dir_y_nxt = DIR_DEC;
            w_by        = 1'b1;
         end else begin
            w_y_nxt = w_y_sum[10:0];
         end
      end else begin
         if (r_y <= YMIN + YSTEP) begin
            w_y_nxt     = YMIN;
            w_dir_y_nxt = DIR_INC;
            w_by        = 1'b1;
         end else begin
            w_y_nxt = r_y - YSTEP;
         end
      end
   end

   // Button synchronizer, pending requests and once-per-frame box update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bt_meta  <= 3'b000;
         r_bt_sync  <= 3'b000;
         r_bt_prev  <= 2'b00;
         r_pend_col <= 1'b0;
         r_pend_ctr <= 1'b0;
         r_x        <= XCTR;
         r_y        <= YCTR;
         r_dir_x    <= DIR_INC;
         r_dir_y    <= DIR_INC;
         r_col      <= 2'd0;
         o_hit      <= 1'b0;
      end else begin
         r_bt_meta <= i_bt;
         r_bt_sync <= r_bt_meta;
         r_bt_prev <= r_bt_sync[2:1];
         o_hit     <= w_bounce;
         if (w_tick) begin
            if (w_pend_ctr) begin
               r_x <= XCTR;
               r_y <= YCTR;
            end else if (!w_paused) begin
               r_x     <= w_x_nxt;
               r_y     <= w_y_nxt;
               r_dir_x <= w_dir_x_nxt;
               r_dir_y <= w_dir_y_nxt;
            end
            if (w_pend_col) begin
               r_col <= r_col + 2'd1;
            end
            r_pend_col <= 1'b0;
            r_pend_ctr <= 1'b0;
         end else begin
            if (w_edge[1]) begin
               r_pend_col <= 1'b1;
            end
            if (w_edge[2]) begin
               r_pend_ctr <= 1'b1;
            end
         end
      end
   end

`ifdef HIT_FLASH_EN
   logic [2:0] r_flash;

   // Flash countdown: reloads on a bounce tick, drains by one per later tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flash <= 3'd0;
      end else if (w_tick) begin
         if (w_bounce) begin
            r_flash <= 3'd7;
         end else if (r_flash != 3'd0) begin
            r_flash <= r_flash - 3'd1;
         end
      end
   end

   assign w_flash_on = (r_flash != 3'd0);
`else
   assign w_flash_on = 1'b0;
`endif

   // Palette lookup for the current colour index.
   always_comb begin
      w_pal = 6'b000000;
      case (r_col)
         2'd0:    w_pal = 6'b110000;
         2'd1:    w_pal = 6'b001100;
         2'd2:    w_pal = 6'b000011;
         default: w_pal = 6'b111100;
      endcase
   end

   // Widened compares keep the box extent from ever wrapping.
   assign w_inside = i_visible
                  && (i_hor_cntr >= r_x)
                  && ({1'b0, i_hor_cntr} <= {1'b0, r_x} + 13'(BOX - 1))
                  && (i_ver_cntr >= r_y)
                  && ({1'b0, i_ver_cntr} <= {1'b0, r_y} + 12'(BOX - 1));
   assign w_pix = w_flash_on ? 6'b111111 : w_pal;

   // Pixel and sync retiming so all pin signals share one clock of latency.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rgb   <= 6'b000000;
         o_hsync <= 1'b0;
         o_vsync <= 1'b0;
      end else begin
         o_rgb   <= w_inside ? w_pix : 6'b000000;
         o_hsync <= i_hsync;
         o_vsync <= i_vsync;
      end
   end

endmodule
